// File: rtl/pipereg_mem_stage.sv
// EX/MEM pipeline register with a one-request data-memory tracker.
// Define PIPEREG_WAITCNT_EN to build the wait_cnt request-latency counter.
module pipereg_mem_stage #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 2,
  parameter int LOAD_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              stall,
  input  logic              flush,
  input  logic              dhit,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [LOAD_W-1:0] load_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [LOAD_W-1:0] load_out,
  output logic              mem_busy,
  output logic [CNT_W-1:0]  wait_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t state;
  logic   in_req;
  logic   hit;
  logic   adv;
  logic   start;

  assign in_req = (state == REQ);
  assign hit    = dhit & in_req;
  assign adv    = en & ~stall & ~in_req;
  assign start  = adv & in_valid & (|in_ctrl);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      load_out  <= '0;
    end else begin
      priority case (1'b1)
        flush: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_ctrl  <= '0;
        end
        hit: begin
          state    <= DONE;
          load_out <= load_in;
          out_ctrl <= '0;
        end
        adv: begin
          state     <= start ? REQ : IDLE;
          out_valid <= in_valid;
          out_data  <= in_data;
          out_ctrl  <= in_valid ? in_ctrl : '0;
        end
        default: ;
      endcase
    end
  end

  // Stall request to the hazard unit; decoded from state only.
  assign mem_busy = in_req;

`ifdef PIPEREG_WAITCNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (!flush) begin
      if (in_req) begin
        if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
      end else if (start) begin
        cnt <= '0;
      end
    end
  end

  assign wait_cnt = cnt;
`else
  assign wait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipereg_mem_stage.sv
// Directed and randomized checks of pipereg_mem_stage against
// a request-level reference model.
module tb_pipereg_mem_stage;

  localparam int DW  = 160;
  localparam int CW  = 2;
  localparam int LW  = 32;
  localparam int NW  = 3;
  localparam int SAT = (1 << NW) - 1;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          en, stall, flush, dhit, in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic [LW-1:0] load_in;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [LW-1:0] load_out;
  logic          mem_busy;
  logic [NW-1:0] wait_cnt;

  pipereg_mem_stage #(
    .DATA_W(DW), .CTRL_W(CW), .LOAD_W(LW), .CNT_W(NW)
  ) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .stall(stall),
    .flush(flush), .dhit(dhit), .in_valid(in_valid),
    .in_data(in_data), .in_ctrl(in_ctrl), .load_in(load_in),
    .out_valid(out_valid), .out_data(out_data),
    .out_ctrl(out_ctrl), .load_out(load_out),
    .mem_busy(mem_busy), .wait_cnt(wait_cnt)
  );

  always #5 CLK = ~CLK;

  // reference model: the resident entry plus "is a request outstanding"
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_ctrl;
  logic [LW-1:0] m_load;
  bit            m_req;
  int            m_reqcycles;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [NW-1:0] exp_cnt();
`ifdef PIPEREG_WAITCNT_EN
    int c;
    c = (m_reqcycles > SAT) ? SAT : m_reqcycles;
    return c[NW-1:0];
`else
    return '0;
`endif
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    chk({tag, ".valid"}, DW'(out_valid), DW'(m_valid));
    chk({tag, ".data"}, out_data, m_data);
    chk({tag, ".ctrl"}, DW'(out_ctrl), DW'(m_ctrl));
    chk({tag, ".load"}, DW'(load_out), DW'(m_load));
    chk({tag, ".busy"}, DW'(mem_busy), DW'(m_req));
    chk({tag, ".wcnt"}, DW'(wait_cnt), DW'(exp_cnt()));
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data = '0;
    m_ctrl = '0;
    m_load = '0;
    m_req = 1'b0;
    m_reqcycles = 0;
  endtask

  task automatic drive(logic e, logic s, logic f, logic h, logic v,
                       logic [CW-1:0] c, logic [DW-1:0] d,
                       logic [LW-1:0] l);
    en = e; stall = s; flush = f; dhit = h; in_valid = v;
    in_ctrl = c; in_data = d; load_in = l;
  endtask

  // one clock edge: advance the model from the driven inputs, then compare
  task automatic cycle(string tag);
    bit adv;
    adv = en && !stall && !m_req;
    if (!flush && m_req) m_reqcycles++;
    if (flush) begin
      m_valid = 1'b0;
      m_data = '0;
      m_ctrl = '0;
      m_req = 1'b0;
    end else if (dhit && m_req) begin
      m_load = load_in;
      m_ctrl = '0;
      m_req = 1'b0;
    end else if (adv) begin
      m_valid = in_valid;
      m_data = in_data;
      m_ctrl = in_valid ? in_ctrl : '0;
      m_req = in_valid && (in_ctrl != '0);
      if (m_req) m_reqcycles = 0;
    end
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  logic [DW-1:0] a5;
  logic [DW-1:0] old_d;
  logic [DW-1:0] new_d;
  logic [NW-1:0] w4;

  initial begin
    a5 = {(DW / 8){8'hA5}};
    drive(0, 0, 0, 0, 0, '0, '0, '0);
    model_reset();
    #3;
    check_all("reset");
    #1 nRST = 1'b1;

    // reset arriving while a request is outstanding
    drive(1, 0, 0, 0, 1, 2'b01, rnd_data(), '0);
    cycle("rst_adv");
    drive(0, 0, 0, 0, 0, '0, '0, '0);
    #1 nRST = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    #1 nRST = 1'b1;

    // basic load, dhit after three wait cycles
    drive(1, 0, 0, 0, 1, 2'b01, a5, '0);
    cycle("ld_adv");
    drive(0, 0, 0, 0, 0, '0, '0, '0);
    for (int i = 0; i < 3; i++) cycle("ld_wait");
    drive(0, 0, 0, 1, 0, '0, '0, 32'hDEADBEEF);
    cycle("ld_hit");
`ifdef PIPEREG_WAITCNT_EN
    w4 = 3'd4;
`else
    w4 = 3'd0;
`endif
    chk("ld_loadval", DW'(load_out), DW'(32'hDEADBEEF));
    chk("ld_dataheld", out_data, a5);
    chk("ld_wcnt4", DW'(wait_cnt), DW'(w4));

    // dhit outside REQ changes nothing
    drive(0, 0, 0, 1, 0, '0, '0, 32'h12345678);
    cycle("hit_done");

    // advance blocked while in REQ, dhit beats en
    old_d = rnd_data();
    new_d = rnd_data();
    drive(1, 0, 0, 0, 1, 2'b10, old_d, '0);
    cycle("blk_adv");
    drive(1, 0, 0, 0, 1, 2'b00, new_d, '0);
    cycle("blk_en1");
    cycle("blk_en2");
    chk("blk_dataheld", out_data, old_d);
    drive(1, 0, 0, 1, 1, 2'b00, new_d, 32'h0BADF00D);
    cycle("blk_hit_en");
    chk("blk_oldpay", out_data, old_d);
    drive(1, 0, 0, 0, 1, 2'b00, new_d, '0);
    cycle("blk_next");
    chk("blk_newpay", out_data, new_d);

    // flush with dhit mid-request
    drive(1, 0, 0, 0, 1, 2'b01, rnd_data(), '0);
    cycle("fl_adv");
    drive(0, 0, 1, 1, 0, '0, '0, 32'hFFFF0000);
    cycle("fl_flush");
    chk("fl_loadheld", DW'(load_out), DW'(32'h0BADF00D));

    // non-memory entries load back to back
    drive(1, 0, 0, 0, 1, 2'b00, rnd_data(), '0);
    cycle("nm_adv1");
    drive(1, 0, 0, 0, 1, 2'b00, rnd_data(), '0);
    cycle("nm_adv2");
    drive(1, 0, 0, 0, 0, 2'b01, rnd_data(), '0);
    cycle("nm_inval");
    drive(1, 1, 0, 0, 1, 2'b01, rnd_data(), '0);
    cycle("nm_stall");

    // counter saturation
    drive(1, 0, 0, 0, 1, 2'b11, rnd_data(), '0);
    cycle("sat_adv");
    drive(0, 0, 0, 0, 0, '0, '0, '0);
    for (int i = 0; i < 10; i++) cycle("sat_wait");
`ifdef PIPEREG_WAITCNT_EN
    chk("sat_top", DW'(wait_cnt), DW'(SAT));
`else
    chk("sat_top", DW'(wait_cnt), '0);
`endif
    drive(0, 0, 0, 1, 0, '0, '0, 32'h13579BDF);
    cycle("sat_hit");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 15) == 0,
            m_req && ($urandom_range(0, 2) == 0),
            $urandom_range(0, 4) != 0, CW'($urandom),
            rnd_data(), $urandom);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
